// File: rtl/rtc_pkg.sv
// Shared widths, limits and types for the time-of-day keeper.
package rtc_pkg;

    localparam int unsigned SEC_MAX = 59;
    localparam int unsigned MIN_MAX = 59;
    localparam int unsigned HR_MAX  = 23;

    localparam int unsigned SEC_W = 6;
    localparam int unsigned MIN_W = 6;
    localparam int unsigned HR_W  = 5;

    typedef struct packed {
        logic [HR_W-1:0]  hr;
        logic [MIN_W-1:0] min;
        logic [SEC_W-1:0] sec;
    } time_t;

    typedef enum logic {StBusy, StReady} set_state_e;

    // 24h hour to 12h display hour: 0 -> 12, 13..23 -> 1..11.
    function automatic logic [HR_W-1:0] to_12h(input logic [HR_W-1:0] hr24);
        if (hr24 == '0) begin
            return HR_W'(12);
        end else if (hr24 > HR_W'(12)) begin
            return hr24 - HR_W'(12);
        end else begin
            return hr24;
        end
    endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-(MAX+1) counter with synchronous load; carry flags the wrap on an increment.
module mod_counter #(
    parameter int unsigned MAX = 59,
    parameter int unsigned W   = 6
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         inc,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] value,
    output logic         carry
);

    logic [W-1:0] value_q, value_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    always_comb begin
        carry   = inc && (value_q == W'(MAX));
        value_d = value_q;
        if (load) begin
            value_d = load_val;
        end else if (inc) begin
            value_d = carry ? '0 : value_q + W'(1);
        end
    end

    assign value = value_q;

endmodule

// File: rtl/rtc_timekeeper.sv
// hh:mm:ss keeper with internal 1 Hz prescaler, validated load handshake and 12/24h display.
// Define RTC_TIMEKEEPER_ALARM_EN to add the sticky hh:mm:00 alarm.
module rtc_timekeeper
    import rtc_pkg::*;
#(
    parameter int unsigned TICK_DIV = 100_000_000,
    parameter int unsigned DIV_W    = $clog2(TICK_DIV)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             run,
    input  logic             mode_12h,
    input  logic             set_valid,
    output logic             set_ready,
    input  logic [SEC_W-1:0] set_sec,
    input  logic [MIN_W-1:0] set_min,
    input  logic [HR_W-1:0]  set_hr,
    output logic             set_err,
    output logic [SEC_W-1:0] sec,
    output logic [MIN_W-1:0] min,
    output logic [HR_W-1:0]  hr,
    output logic             pm,
    output logic             tick_1hz,
    output logic             day_wrap
`ifdef RTC_TIMEKEEPER_ALARM_EN
    ,
    input  logic [HR_W-1:0]  alarm_hr,
    input  logic [MIN_W-1:0] alarm_min,
    input  logic             alarm_arm,
    input  logic             alarm_clr,
    output logic             alarm_irq
`endif
);

    set_state_e       state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             tick_q, day_wrap_q, set_err_q;
    logic             accept, set_ok, load, reject, wrap, adv;
    logic             sec_carry, min_carry, hr_carry;
    time_t            cur;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StBusy;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StReady: if (set_valid) state_d = StBusy;
            StBusy:  state_d = StReady;
            default: state_d = StBusy;
        endcase
    end

    always_comb begin
        set_ready = (state_q == StReady);
    end

    always_comb begin
        accept = set_valid && set_ready;
        set_ok = (set_sec <= SEC_W'(SEC_MAX)) && (set_min <= MIN_W'(MIN_MAX)) &&
                 (set_hr <= HR_W'(HR_MAX));
        load   = accept && set_ok;
        reject = accept && !set_ok;
        wrap   = run && (div_q == DIV_W'(TICK_DIV - 1));
        // Any accepted request owns the cycle, so a coincident wrap never advances time.
        adv    = wrap && !accept;
        div_d  = div_q;
        if (load) begin
            div_d = '0;
        end else if (run && !reject) begin
            div_d = wrap ? '0 : div_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_q      <= '0;
            tick_q     <= 1'b0;
            day_wrap_q <= 1'b0;
            set_err_q  <= 1'b0;
        end else begin
            div_q      <= div_d;
            tick_q     <= adv;
            day_wrap_q <= hr_carry;
            set_err_q  <= reject;
        end
    end

    mod_counter #(.MAX(SEC_MAX), .W(SEC_W)) u_sec (
        .clk      (clk),
        .reset_n  (reset_n),
        .inc      (adv),
        .load     (load),
        .load_val (set_sec),
        .value    (cur.sec),
        .carry    (sec_carry)
    );

    mod_counter #(.MAX(MIN_MAX), .W(MIN_W)) u_min (
        .clk      (clk),
        .reset_n  (reset_n),
        .inc      (sec_carry),
        .load     (load),
        .load_val (set_min),
        .value    (cur.min),
        .carry    (min_carry)
    );

    mod_counter #(.MAX(HR_MAX), .W(HR_W)) u_hr (
        .clk      (clk),
        .reset_n  (reset_n),
        .inc      (min_carry),
        .load     (load),
        .load_val (set_hr),
        .value    (cur.hr),
        .carry    (hr_carry)
    );

    always_comb begin
        sec      = cur.sec;
        min      = cur.min;
        hr       = mode_12h ? to_12h(cur.hr) : cur.hr;
        pm       = mode_12h && (cur.hr >= HR_W'(12));
        tick_1hz = tick_q;
        day_wrap = day_wrap_q;
        set_err  = set_err_q;
    end

`ifdef RTC_TIMEKEEPER_ALARM_EN
    logic  alarm_q, alarm_d, alarm_hit;
    time_t nxt;

    // Time after this cycle's advance; only meaningful when the seconds wrap to :00.
    always_comb begin
        nxt.sec   = '0;
        nxt.min   = min_carry ? '0 : cur.min + MIN_W'(1);
        nxt.hr    = hr_carry ? '0 : (min_carry ? cur.hr + HR_W'(1) : cur.hr);
        alarm_hit = sec_carry && alarm_arm && (nxt.min == alarm_min) && (nxt.hr == alarm_hr);
        alarm_d   = alarm_clr ? 1'b0 : (alarm_q || alarm_hit);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            alarm_q <= 1'b0;
        end else begin
            alarm_q <= alarm_d;
        end
    end

    assign alarm_irq = alarm_q;
`endif

endmodule

// File: tb/tb_rtc_timekeeper.sv
// Self-checking bench for rtc_timekeeper with a 4-cycle prescaler.
module tb_rtc_timekeeper;
    import rtc_pkg::*;

    localparam int unsigned TICK_DIV = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       run = 1'b0;
    logic       mode_12h = 1'b0;
    logic       set_valid = 1'b0;
    logic [5:0] set_sec = '0;
    logic [5:0] set_min = '0;
    logic [4:0] set_hr = '0;
    logic       set_ready, set_err, pm, tick_1hz, day_wrap;
    logic [5:0] sec, min;
    logic [4:0] hr;
`ifdef RTC_TIMEKEEPER_ALARM_EN
    logic [4:0] alarm_hr = '0;
    logic [5:0] alarm_min = '0;
    logic       alarm_arm = 1'b0;
    logic       alarm_clr = 1'b0;
    logic       alarm_irq;
`endif

    rtc_timekeeper #(.TICK_DIV(TICK_DIV)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .run       (run),
        .mode_12h  (mode_12h),
        .set_valid (set_valid),
        .set_ready (set_ready),
        .set_sec   (set_sec),
        .set_min   (set_min),
        .set_hr    (set_hr),
        .set_err   (set_err),
        .sec       (sec),
        .min       (min),
        .hr        (hr),
        .pm        (pm),
        .tick_1hz  (tick_1hz),
        .day_wrap  (day_wrap)
`ifdef RTC_TIMEKEEPER_ALARM_EN
        ,
        .alarm_hr  (alarm_hr),
        .alarm_min (alarm_min),
        .alarm_arm (alarm_arm),
        .alarm_clr (alarm_clr),
        .alarm_irq (alarm_irq)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] s;
        logic [5:0] m;
        logic [4:0] h;
        logic       mode;
        logic       err;
        logic [5:0] es;
        logic [5:0] em;
        logic [4:0] eh;
        logic       epm;
    } vec_t;

    vec_t vecs[10];
    vec_t exp_q[$];
    int   n_pass = 0;
    int   n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, required %0d", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_tick(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!tick_1hz && n < 20);
        check("tick_seen", 32'(tick_1hz), 32'd1);
    endtask

    // Drive one load, queue its expected result, compare once the accept edge has passed.
    task automatic do_load(input vec_t v);
        int   guard = 0;
        vec_t e;
        mode_12h = v.mode;
        while (!set_ready && guard < 10) begin
            step();
            guard++;
        end
        check("ready_before_load", 32'(set_ready), 32'd1);
        set_sec   = v.s;
        set_min   = v.m;
        set_hr    = v.h;
        set_valid = 1'b1;
        exp_q.push_back(v);
        step();
        set_valid = 1'b0;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("load_err", 32'(set_err), 32'(e.err));
            check("load_sec", 32'(sec), 32'(e.es));
            check("load_min", 32'(min), 32'(e.em));
            check("load_hr", 32'(hr), 32'(e.eh));
            check("load_pm", 32'(pm), 32'(e.epm));
        end
        check("ready_busy", 32'(set_ready), 32'd0);
        step();
        check("err_one_cycle", 32'(set_err), 32'd0);
        check("ready_back", 32'(set_ready), 32'd1);
    endtask

    initial begin
        int   n;
        int   ticks;
        vec_t v;

        vecs[0] = '{s:0,  m:0,  h:0,  mode:1, err:0, es:0,  em:0,  eh:12, epm:1'b0};
        vecs[1] = '{s:0,  m:0,  h:12, mode:1, err:0, es:0,  em:0,  eh:12, epm:1'b1};
        vecs[2] = '{s:0,  m:0,  h:13, mode:1, err:0, es:0,  em:0,  eh:1,  epm:1'b1};
        vecs[3] = '{s:30, m:45, h:23, mode:1, err:0, es:30, em:45, eh:11, epm:1'b1};
        vecs[4] = '{s:10, m:10, h:13, mode:0, err:0, es:10, em:10, eh:13, epm:1'b0};
        vecs[5] = '{s:60, m:10, h:5,  mode:0, err:1, es:10, em:10, eh:13, epm:1'b0};
        vecs[6] = '{s:5,  m:60, h:5,  mode:0, err:1, es:10, em:10, eh:13, epm:1'b0};
        vecs[7] = '{s:5,  m:5,  h:24, mode:0, err:1, es:10, em:10, eh:13, epm:1'b0};
        vecs[8] = '{s:59, m:59, h:11, mode:1, err:0, es:59, em:59, eh:11, epm:1'b0};
        vecs[9] = '{s:1,  m:2,  h:0,  mode:0, err:0, es:1,  em:2,  eh:0,  epm:1'b0};

        // Reset values
        repeat (3) step();
        check("rst_sec", 32'(sec), 32'd0);
        check("rst_hr24", 32'(hr), 32'd0);
        check("rst_pm", 32'(pm), 32'd0);
        check("rst_tick", 32'(tick_1hz), 32'd0);
        check("rst_day_wrap", 32'(day_wrap), 32'd0);
        check("rst_set_err", 32'(set_err), 32'd0);
        check("rst_ready", 32'(set_ready), 32'd0);
        mode_12h = 1'b1;
        #1;
        check("rst_hr12", 32'(hr), 32'd12);
        mode_12h = 1'b0;

        // Free-running ticks after release
        reset_n = 1'b1;
        run     = 1'b1;
        step();
        check("ready_after_first_edge", 32'(set_ready), 32'd1);
        wait_tick(n);
        check("first_tick_latency", 32'(n), 32'd3);
        check("sec_after_tick1", 32'(sec), 32'd1);
        wait_tick(n);
        check("tick_period", 32'(n), 32'd4);
        check("sec_after_tick2", 32'(sec), 32'd2);
        step();
        check("tick_pulse_width", 32'(tick_1hz), 32'd0);

        // Table of loads: range checks and 12/24h mapping
        run = 1'b0;
        for (int i = 0; i < 10; i++) do_load(vecs[i]);

        // Day wrap
        v = '{s:58, m:59, h:23, mode:0, err:0, es:58, em:59, eh:23, epm:1'b0};
        do_load(v);
        run = 1'b1;
        wait_tick(n);
        check("wrap_tick_latency", 32'(n), 32'd4);
        check("sec_59", 32'(sec), 32'd59);
        check("no_early_day_wrap", 32'(day_wrap), 32'd0);
        wait_tick(n);
        check("midnight_sec", 32'(sec), 32'd0);
        check("midnight_min", 32'(min), 32'd0);
        check("midnight_hr", 32'(hr), 32'd0);
        check("day_wrap_with_tick", 32'(day_wrap), 32'd1);
        step();
        check("day_wrap_width", 32'(day_wrap), 32'd0);

        // Freeze with run=0 part-way through a second
        run = 1'b0;
        v = '{s:0, m:0, h:0, mode:0, err:0, es:0, em:0, eh:0, epm:1'b0};
        do_load(v);
        run = 1'b1;
        step();
        step();
        run   = 1'b0;
        ticks = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            ticks += int'(tick_1hz);
        end
        check("no_tick_while_stopped", 32'(ticks), 32'd0);
        check("sec_frozen", 32'(sec), 32'd0);
        run = 1'b1;
        wait_tick(n);
        check("resume_latency", 32'(n), 32'd2);
        check("sec_after_resume", 32'(sec), 32'd1);

        // Load coincident with the prescaler wrap
        step();
        step();
        step();
        set_sec   = 6'd3;
        set_min   = 6'd2;
        set_hr    = 5'd1;
        set_valid = 1'b1;
        step();
        set_valid = 1'b0;
        check("coincident_no_tick", 32'(tick_1hz), 32'd0);
        check("coincident_sec", 32'(sec), 32'd3);
        check("coincident_min", 32'(min), 32'd2);
        check("coincident_hr", 32'(hr), 32'd1);
        wait_tick(n);
        check("tick_after_coincident", 32'(n), 32'd4);
        check("sec_after_coincident", 32'(sec), 32'd4);

        // Asynchronous reset mid-handshake
        set_sec   = 6'd20;
        set_min   = 6'd20;
        set_hr    = 5'd20;
        set_valid = 1'b1;
        step();
        set_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        check("areset_sec", 32'(sec), 32'd0);
        check("areset_min", 32'(min), 32'd0);
        check("areset_hr", 32'(hr), 32'd0);
        check("areset_ready", 32'(set_ready), 32'd0);
        check("areset_tick", 32'(tick_1hz), 32'd0);
        mode_12h = 1'b1;
        #1;
        check("areset_hr12", 32'(hr), 32'd12);
        check("areset_pm", 32'(pm), 32'd0);
        mode_12h = 1'b0;
        step();
        reset_n = 1'b1;
        step();
        check("ready_after_rerelease", 32'(set_ready), 32'd1);
        check("sec_after_rerelease", 32'(sec), 32'd0);

`ifdef RTC_TIMEKEEPER_ALARM_EN
        run       = 1'b0;
        alarm_hr  = 5'd7;
        alarm_min = 6'd0;
        alarm_arm = 1'b1;
        check("alarm_reset", 32'(alarm_irq), 32'd0);
        v = '{s:59, m:59, h:6, mode:0, err:0, es:59, em:59, eh:6, epm:1'b0};
        do_load(v);
        check("alarm_idle", 32'(alarm_irq), 32'd0);
        run = 1'b1;
        wait_tick(n);
        check("alarm_hr_reached", 32'(hr), 32'd7);
        check("alarm_fires", 32'(alarm_irq), 32'd1);
        repeat (5) step();
        check("alarm_sticky", 32'(alarm_irq), 32'd1);
        alarm_clr = 1'b1;
        step();
        alarm_clr = 1'b0;
        check("alarm_cleared", 32'(alarm_irq), 32'd0);
        run = 1'b0;
        v = '{s:0, m:0, h:7, mode:0, err:0, es:0, em:0, eh:7, epm:1'b0};
        do_load(v);
        check("alarm_not_from_load", 32'(alarm_irq), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
